seg_display_scanner: RTL and testbench

Time-multiplexed 4-digit seven-segment driver that consumes the 4-bit digit values produced by the digit counter chain and drives the board's shared segment bus and per-digit anodes. It snapshots all digits once per refresh frame to prevent tearing, decodes hex to segment patterns, and applies leading-zero blanking, per-digit blinking and anti-ghosting dead time. It sits between the counter chain and the top-level display pins.

---
 rtl/seg_display_scanner.sv | 84 ++++++++
 tb/tb_seg_display_scanner.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seg_display_scanner.sv
// seg_display_scanner: time-multiplexed 4-digit seven-segment driver with frame snapshot, hex decode, blanking, blink and dead time
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   digit0..digit3    hex digit values, digit0 rightmost
//   dp_mask, blink_en per-digit decimal point and blink requests
//   blank_lz          leading-zero blanking enable (live level, not snapshotted)
//   seg, dp, an       segment bus (seg[0]=a), decimal point, digit enables
//   frame_tick        one-cycle pulse in slot 0's dead cycle
module seg_display_scanner #(
  parameter int REFRESH_DIV = 1000,
  parameter int BLINK_DIV = 250,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dp_mask,
  input  logic [3:0] blink_en,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(BLINK_DIV + 1);
  localparam logic [15:0][6:0] HEX = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [PW-1:0] presc, presc_n;
  logic [1:0] slot, slot_n;
  logic [FW-1:0] frame_cnt, frame_cnt_n;
  logic blink_phase, phase_n, frame, blank;
  logic [3:0][3:0] sh_digit, digit_n;
  logic [3:0] sh_dp, sh_blink, dp_n, blink_n, zero_up, cur;
  // Output registers are fed from next-state values so the new slot's
  // segments (and a freshly loaded snapshot) appear in the dead cycle itself.
  always_comb begin
    presc_n = presc == PW'(REFRESH_DIV - 1) ? '0 : presc + 1'b1;
    slot_n = presc_n == '0 ? slot + 2'd1 : slot;
    frame = presc_n == '0 && slot == 2'd3;
    frame_cnt_n = !frame ? frame_cnt : frame_cnt == FW'(BLINK_DIV - 1) ? '0 : frame_cnt + 1'b1;
    phase_n = blink_phase ^ (frame && frame_cnt_n == '0);
    digit_n = frame ? {digit3, digit2, digit1, digit0} : sh_digit;
    dp_n = frame ? dp_mask : sh_dp;
    blink_n = frame ? blink_en : sh_blink;
    cur = digit_n[slot_n];
    // zero_up[k]: digits k..3 all zero; digit 0 is exempt from leading-zero blanking
    zero_up[3] = digit_n[3] == 4'd0;
    zero_up[2] = zero_up[3] && digit_n[2] == 4'd0;
    zero_up[1] = zero_up[2] && digit_n[1] == 4'd0;
    zero_up[0] = 1'b0;
    blank = (blank_lz && zero_up[slot_n]) || (blink_n[slot_n] && phase_n);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      presc <= '0;
      slot <= '0;
      frame_cnt <= '0;
      blink_phase <= 1'b0;
      sh_digit <= '0;
      sh_dp <= '0;
      sh_blink <= '0;
      frame_tick <= 1'b0;
      seg <= {7{SEG_ACTIVE_LOW}};
      dp <= SEG_ACTIVE_LOW;
      an <= {4{AN_ACTIVE_LOW}};
    end else begin
      presc <= presc_n;
      slot <= slot_n;
      frame_cnt <= frame_cnt_n;
      blink_phase <= phase_n;
      sh_digit <= digit_n;
      sh_dp <= dp_n;
      sh_blink <= blink_n;
      frame_tick <= frame;
      seg <= (blank ? 7'd0 : HEX[cur]) ^ {7{SEG_ACTIVE_LOW}};
      dp <= (!blank && dp_n[slot_n]) ^ SEG_ACTIVE_LOW;
      an <= ((blank || presc_n == '0) ? 4'd0 : 4'b1 << slot_n) ^ {4{AN_ACTIVE_LOW}};
    end
endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner: scoreboard bench for seg_display_scanner
module tb_seg_display_scanner;
  localparam int RD = 4;
  localparam int BD = 2;
  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
    logic ft;
    string tag;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] digs;
  logic [3:0] dpm, bl;
  logic lz;
  logic [6:0] seg;
  logic dp;
  logic [3:0] an;
  logic frame_tick;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int fidx = 0;

  always #5 clk = ~clk;

  seg_display_scanner #(.REFRESH_DIV(RD), .BLINK_DIV(BD), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst),
    .digit0(digs[3:0]), .digit1(digs[7:4]), .digit2(digs[11:8]), .digit3(digs[15:12]),
    .dp_mask(dpm), .blink_en(bl), .blank_lz(lz),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      assert ({an, seg, dp, frame_tick} === {e.an, e.seg, e.dp, e.ft}) else begin
        errors++;
        $error("FAIL %s: got an=%b seg=%h dp=%b ft=%b, expected an=%b seg=%h dp=%b ft=%b",
               e.tag, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.ft);
      end
    end

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input logic f, input string t);
    exp_t e;
    e.an = a;
    e.seg = s;
    e.dp = d;
    e.ft = f;
    e.tag = t;
    q.push_back(e);
  endtask

  task automatic push_inactive(input string t);
    push(4'hF, 7'h7F, 1'b1, 1'b0, t);
  endtask

  // Expected outputs for one whole frame, starting with the current (dead) cycle.
  task automatic expect_frame(input logic first);
    logic [15:0] sd;
    logic [3:0] sdp, sbl, nib;
    logic ph, zero, blank;
    sd = first ? 16'h0 : digs;
    sdp = first ? 4'h0 : dpm;
    sbl = first ? 4'h0 : bl;
    ph = ((fidx / BD) % 2) == 1;
    for (int s = 0; s < 4; s++) begin
      nib = sd[4*s +: 4];
      zero = (sd >> (4 * s)) == 16'h0;
      blank = (lz && s != 0 && zero) || (sbl[s] && ph);
      for (int p = 0; p < RD; p++)
        if (first && s == 0 && p == 0) push_inactive($sformatf("f%0d_release", fidx));
        else push((blank || p == 0) ? 4'hF : ~(4'b1 << s), blank ? 7'h7F : ~DEC[nib],
                  blank ? 1'b1 : ~sdp[s], s == 0 && p == 0, $sformatf("f%0d_s%0d_p%0d", fidx, s, p));
    end
    fidx++;
  endtask

  task automatic run_frame(input logic first, input logic [15:0] nd, input logic [3:0] ndp, input logic [3:0] nbl,
                           input logic nlz, input logic mid_en, input logic [15:0] mid_d);
    expect_frame(first);
    repeat (8) @(posedge clk);
    #1;
    if (mid_en) digs = mid_d;
    repeat (7) @(posedge clk);
    #1;
    digs = nd;
    dpm = ndp;
    bl = nbl;
    lz = nlz;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    digs = 16'h4321;
    dpm = 4'h0;
    bl = 4'h0;
    lz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      push_inactive("in_reset");
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    fidx = 0;
    run_frame(1'b1, 16'h4321, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0);
    run_frame(1'b0, 16'h0500, 4'h0, 4'h0, 1'b1, 1'b0, 16'h0);
    run_frame(1'b0, 16'h0500, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0);
    run_frame(1'b0, 16'h0000, 4'h0, 4'h0, 1'b1, 1'b0, 16'h0);
    run_frame(1'b0, 16'h0003, 4'h0, 4'h0, 1'b1, 1'b0, 16'h0);
    run_frame(1'b0, 16'h0009, 4'h0, 4'h0, 1'b1, 1'b1, 16'h0009);
    run_frame(1'b0, 16'h4321, 4'b0010, 4'b0001, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) run_frame(1'b0, 16'h4321, 4'b0010, 4'b0001, 1'b0, 1'b0, 16'h0);
    expect_frame(1'b0);
    repeat (9) @(posedge clk);
    #1;
    q.delete();
    rst = 1'b0;
    push_inactive("abort_slot2");
    @(posedge clk);
    #1;
    push_inactive("abort_hold");
    @(posedge clk);
    #1;
    rst = 1'b1;
    fidx = 0;
    run_frame(1'b1, 16'h4321, 4'b0010, 4'b0001, 1'b0, 1'b0, 16'h0);
    run_frame(1'b0, 16'h4321, 4'b0010, 4'b0001, 1'b0, 1'b0, 16'h0);
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drained: got %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
